// File: rtl/ws2812_pkg.sv
// Shared types, widths and colour helpers for the WS2812 sequencer.
package ws2812_pkg;

    localparam int RGB_W     = 24;
    localparam int LED_IDX_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_CYCLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Byte rotate left: {R,G,B} -> {G,B,R}, so R lands in the B slot.
    function automatic logic [RGB_W-1:0] rgb_rotate(input logic [RGB_W-1:0] c);
        return {c[15:0], c[23:16]};
    endfunction

endpackage

// File: rtl/ws2812_ctrl_if.sv
// Configuration and host-write port of the WS2812 sequencer.
interface ws2812_ctrl_if;
    import ws2812_pkg::*;

    logic                 cfg_valid;
    logic [1:0]           cfg_mode;
    logic [RGB_W-1:0]     cfg_rgb;
    logic                 host_valid;
    logic                 host_ready;
    logic [LED_IDX_W-1:0] host_led;
    logic [RGB_W-1:0]     host_rgb;

    modport master (
        output cfg_valid, cfg_mode, cfg_rgb,
        output host_valid, host_led, host_rgb,
        input  host_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_rgb,
        input  host_valid, host_led, host_rgb,
        output host_ready
    );
endinterface

// File: rtl/ws2812_frame_timer.sv
// Inter-frame idle timer: start loads FRAME_TICKS-1, expired fires on the
// last counted cycle so the full idle gap is exactly FRAME_TICKS cycles.
module ws2812_frame_timer #(
    parameter int FRAME_TICKS = 524288
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int TW = $clog2(FRAME_TICKS);

    logic [TW-1:0] count_r;
    logic          run_r;

    assign expired = run_r && (count_r == {TW{1'b0}});

    // Down-counter; clear wins over start so a restart never inherits a stale gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {TW{1'b0}};
            run_r   <= 1'b0;
        end else if (clear) begin
            count_r <= {TW{1'b0}};
            run_r   <= 1'b0;
        end else if (start) begin
            count_r <= TW'(FRAME_TICKS - 1);
            run_r   <= 1'b1;
        end else if (run_r) begin
            if (count_r == {TW{1'b0}}) begin
                run_r <= 1'b0;
            end else begin
                count_r <= count_r - TW'(1);
            end
        end else begin
            count_r <= count_r;
            run_r   <= run_r;
        end
    end

endmodule

// File: rtl/ws2812_ctrl.sv
// Animation sequencer and host/sweep write arbiter in front of the ws2812 driver.
module ws2812_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 64,
    parameter int FRAME_TICKS = 524288
) (
    input  logic                 clk,
    input  logic                 reset,
    ws2812_ctrl_if.slave         bus,
    output logic [LED_IDX_W-1:0] led_num,
    output logic [RGB_W-1:0]     rgb_data,
    output logic                 write,
    output logic                 frame_done
);
    localparam logic [LED_IDX_W-1:0] LED_CNT  = LED_IDX_W'(NUM_LEDS);
    localparam logic [LED_IDX_W-1:0] LAST_IDX = LED_IDX_W'(NUM_LEDS - 1);

    state_e               state_r;
    mode_e                mode_r;
    logic [RGB_W-1:0]     base_rgb_r;
    logic [RGB_W-1:0]     cyc_rgb_r;
    logic [LED_IDX_W-1:0] pos_r;
    logic [LED_IDX_W-1:0] idx_r;
    logic                 sweep_last_r;
    logic                 write_r;
    logic [LED_IDX_W-1:0] led_num_r;
    logic [RGB_W-1:0]     rgb_data_r;
    logic                 frame_done_r;

    logic                 host_hs_s;
    logic                 timer_expired_s;
    logic                 sweep_go_s;
    mode_e                eff_mode_s;
    logic [RGB_W-1:0]     eff_base_s;
    logic [RGB_W-1:0]     eff_cyc_s;
    logic [LED_IDX_W-1:0] eff_pos_s;
    logic [LED_IDX_W-1:0] eff_idx_s;
    logic [RGB_W-1:0]     sweep_rgb_s;

    // Colour of sweep pixel idx for the given mode and frame state.
    function automatic logic [RGB_W-1:0] pixel_rgb(
        input mode_e                m,
        input logic [RGB_W-1:0]     base,
        input logic [RGB_W-1:0]     cyc,
        input logic [LED_IDX_W-1:0] pos,
        input logic [LED_IDX_W-1:0] idx
    );
        logic [RGB_W-1:0] c;
        case (m)
            MODE_OFF:   c = {RGB_W{1'b0}};
            MODE_FILL:  c = base;
            MODE_CHASE: c = (idx == pos) ? base : {RGB_W{1'b0}};
            MODE_CYCLE: c = cyc;
            default:    c = {RGB_W{1'b0}};
        endcase
        return c;
    endfunction

    assign bus.host_ready = ~reset;
    assign host_hs_s      = bus.host_valid & bus.host_ready;

    assign led_num    = led_num_r;
    assign rgb_data   = rgb_data_r;
    assign write      = write_r;
    assign frame_done = frame_done_r;

    ws2812_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (sweep_last_r),
        .clear   (bus.cfg_valid),
        .expired (timer_expired_s)
    );

    // Effective sweep context this cycle: a fresh cfg, a frame advance out of
    // WAIT, or the ongoing sweep. Folding cfg/advance in here lets index 0 go
    // out on the very edge that starts the sweep.
    always_comb begin
        eff_mode_s = mode_r;
        eff_base_s = base_rgb_r;
        eff_cyc_s  = cyc_rgb_r;
        eff_pos_s  = pos_r;
        eff_idx_s  = idx_r;
        sweep_go_s = 1'b0;
        if (bus.cfg_valid) begin
            eff_mode_s = mode_e'(bus.cfg_mode);
            eff_base_s = bus.cfg_rgb;
            eff_cyc_s  = bus.cfg_rgb;
            eff_pos_s  = {LED_IDX_W{1'b0}};
            eff_idx_s  = {LED_IDX_W{1'b0}};
            sweep_go_s = 1'b1;
        end else if ((state_r == ST_WAIT) && timer_expired_s && (mode_r != MODE_OFF)) begin
            eff_idx_s  = {LED_IDX_W{1'b0}};
            sweep_go_s = 1'b1;
            if (mode_r == MODE_CHASE) begin
                eff_pos_s = (pos_r >= LAST_IDX) ? {LED_IDX_W{1'b0}} : pos_r + 8'd1;
            end else begin
                eff_pos_s = pos_r;
            end
            if (mode_r == MODE_CYCLE) begin
                eff_cyc_s = rgb_rotate(cyc_rgb_r);
            end else begin
                eff_cyc_s = cyc_rgb_r;
            end
        end else begin
            sweep_go_s = (state_r == ST_SWEEP);
        end
        sweep_rgb_s = pixel_rgb(eff_mode_s, eff_base_s, eff_cyc_s, eff_pos_s, eff_idx_s);
    end

    // Sweep FSM and registered driver port; a host handshake takes the slot
    // and the sweep index simply holds for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            mode_r       <= MODE_OFF;
            base_rgb_r   <= {RGB_W{1'b0}};
            cyc_rgb_r    <= {RGB_W{1'b0}};
            pos_r        <= {LED_IDX_W{1'b0}};
            idx_r        <= {LED_IDX_W{1'b0}};
            sweep_last_r <= 1'b0;
            write_r      <= 1'b0;
            led_num_r    <= {LED_IDX_W{1'b0}};
            rgb_data_r   <= {RGB_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            mode_r       <= eff_mode_s;
            base_rgb_r   <= eff_base_s;
            cyc_rgb_r    <= eff_cyc_s;
            pos_r        <= eff_pos_s;
            frame_done_r <= sweep_last_r;
            sweep_last_r <= 1'b0;
            write_r      <= 1'b0;

            if (host_hs_s) begin
                if (bus.host_led < LED_CNT) begin
                    write_r    <= 1'b1;
                    led_num_r  <= bus.host_led;
                    rgb_data_r <= bus.host_rgb;
                end
            end else if (sweep_go_s) begin
                write_r    <= 1'b1;
                led_num_r  <= eff_idx_s;
                rgb_data_r <= sweep_rgb_s;
            end

            if (sweep_go_s) begin
                if (host_hs_s) begin
                    state_r <= ST_SWEEP;
                    idx_r   <= eff_idx_s;
                end else if (eff_idx_s >= LAST_IDX) begin
                    state_r      <= ST_WAIT;
                    idx_r        <= {LED_IDX_W{1'b0}};
                    sweep_last_r <= 1'b1;
                end else begin
                    state_r <= ST_SWEEP;
                    idx_r   <= eff_idx_s + 8'd1;
                end
            end else if ((state_r == ST_WAIT) && timer_expired_s) begin
                state_r <= ST_IDLE;
                idx_r   <= {LED_IDX_W{1'b0}};
            end else begin
                state_r <= state_r;
                idx_r   <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Self-checking bench for ws2812_ctrl with NUM_LEDS=8, FRAME_TICKS=16.
module tb_ws2812_ctrl;
    import ws2812_pkg::*;

    localparam int NL = 8;
    localparam int FT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic        write;
    logic        frame_done;

    ws2812_ctrl_if bus();

    ws2812_ctrl #(.NUM_LEDS(NL), .FRAME_TICKS(FT)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .led_num    (led_num),
        .rgb_data   (rgb_data),
        .write      (write),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  led;
        logic [23:0] rgb;
    } wr_t;

    typedef struct {
        logic [7:0]  led;
        logic [23:0] rgb;
        bit          exp_wr;
    } host_vec_t;

    wr_t         exp_q[$];
    int          done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    logic [7:0]  last_led = 8'd0;
    logic [23:0] last_rgb = 24'd0;
    host_vec_t   hv[6];
    logic [23:0] cyc_cols[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected none (cycle %0d)", name, act, cyc);
    endtask

    // Advance one clock, then compare outputs against the scoreboards.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (write) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                fail_now("spurious_write", {16'h0, 8'h0, led_num});
            end else begin
                e = exp_q.pop_front();
                check("write_cycle", 32'(cyc), 32'(e.cyc));
                check("write_led", 32'(led_num), 32'(e.led));
                check("write_rgb", 32'(rgb_data), 32'(e.rgb));
                last_led = e.led;
                last_rgb = e.rgb;
            end
        end else begin
            check("hold_led", 32'(led_num), 32'(last_led));
            check("hold_rgb", 32'(rgb_data), 32'(last_rgb));
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            fail_now("missed_write", {24'h0, e.led});
        end
        if (frame_done) begin
            if (done_q.size() == 0) begin
                fail_now("spurious_frame_done", 32'(cyc));
            end else begin
                check("frame_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
        if (done_q.size() > 0 && done_q[0] < cyc) begin
            fail_now("missed_frame_done", 32'(done_q.pop_front()));
        end
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick();
    endtask

    // Expected sweep: chase < 0 means every pixel gets col.
    task automatic push_frame(input int first, input logic [23:0] col, input int chase);
        wr_t e;
        for (int i = 0; i < NL; i++) begin
            e.cyc = first + i;
            e.led = 8'(i);
            e.rgb = (chase < 0 || chase == i) ? col : 24'h000000;
            exp_q.push_back(e);
        end
        done_q.push_back(first + NL);
    endtask

    task automatic push_one(input int c, input logic [7:0] led, input logic [23:0] rgb);
        wr_t e;
        e.cyc = c;
        e.led = led;
        e.rgb = rgb;
        exp_q.push_back(e);
    endtask

    task automatic do_cfg(input logic [1:0] m, input logic [23:0] rgb);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = m;
        bus.cfg_rgb   = rgb;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic drained(input string name);
        check(name, 32'(exp_q.size() + done_q.size()), 32'd0);
    endtask

    initial begin
        int c;
        int w0;
        hv[0] = '{8'd9,   24'h123456, 1'b0};
        hv[1] = '{8'd2,   24'h0000AA, 1'b1};
        hv[2] = '{8'd7,   24'hFF0000, 1'b1};
        hv[3] = '{8'd8,   24'h111111, 1'b0};
        hv[4] = '{8'd255, 24'h222222, 1'b0};
        hv[5] = '{8'd0,   24'h0F0F0F, 1'b1};
        cyc_cols[0] = 24'h102030;
        cyc_cols[1] = 24'h203010;
        cyc_cols[2] = 24'h301020;
        cyc_cols[3] = 24'h102030;

        reset          = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_mode   = 2'd0;
        bus.cfg_rgb    = 24'h0;
        bus.host_valid = 1'b0;
        bus.host_led   = 8'h0;
        bus.host_rgb   = 24'h0;
        tick();
        tick();
        check("rst_write", 32'(write), 32'd0);
        check("rst_led", 32'(led_num), 32'd0);
        check("rst_rgb", 32'(rgb_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_host_ready", 32'(bus.host_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("host_ready_after_rst", 32'(bus.host_ready), 32'd1);
        run_until(10);

        // FILL: two frames, 24 cycles first-write to first-write.
        c = cyc;
        push_frame(c + 1, 24'h100000, -1);
        push_frame(c + 25, 24'h100000, -1);
        do_cfg(2'd1, 24'h100000);
        run_until(c + 34);
        drained("fill_drained");

        // CHASE: nine frames, position wraps back to 0 in frame 8.
        c = cyc;
        for (int k = 0; k < 9; k++) push_frame(c + 1 + 24 * k, 24'h001000, k % NL);
        do_cfg(2'd2, 24'h001000);
        run_until(c + 1 + 24 * 8 + NL + 1);
        drained("chase_drained");

        // CYCLE: byte rotation per frame.
        c = cyc;
        for (int k = 0; k < 4; k++) push_frame(c + 1 + 24 * k, cyc_cols[k], -1);
        do_cfg(2'd3, 24'h102030);
        run_until(c + 1 + 24 * 3 + NL + 1);
        drained("cycle_drained");

        // Host write stalls sweep index 2 by one cycle.
        c = cyc;
        w0 = wr_seen;
        push_one(c + 1, 8'd0, 24'h0000FF);
        push_one(c + 2, 8'd1, 24'h0000FF);
        push_one(c + 3, 8'd3, 24'hABCDEF);
        for (int i = 2; i < NL; i++) push_one(c + 2 + i, 8'(i), 24'h0000FF);
        done_q.push_back(c + 10);
        do_cfg(2'd1, 24'h0000FF);
        tick();
        bus.host_valid = 1'b1;
        bus.host_led   = 8'd3;
        bus.host_rgb   = 24'hABCDEF;
        check("stall_host_ready", 32'(bus.host_ready), 32'd1);
        tick();
        bus.host_valid = 1'b0;
        run_until(c + 11);
        check("stall_write_count", 32'(wr_seen - w0), 32'd9);
        drained("stall_drained");

        // OFF after FILL: one zero sweep, then silence.
        c = cyc;
        push_frame(c + 1, 24'h000000, -1);
        do_cfg(2'd0, 24'h00FFFF);
        run_until(c + NL + 1 + 100);
        drained("off_drained");

        // Host vectors in IDLE, including out-of-range indices.
        for (int v = 0; v < 6; v++) begin
            bus.host_valid = 1'b1;
            bus.host_led   = hv[v].led;
            bus.host_rgb   = hv[v].rgb;
            check("host_ready_idle", 32'(bus.host_ready), 32'd1);
            if (hv[v].exp_wr) push_one(cyc + 1, hv[v].led, hv[v].rgb);
            tick();
            bus.host_valid = 1'b0;
            tick();
            tick();
        end
        drained("host_table_drained");

        // cfg and host in the same cycle: host first, sweep follows.
        c = cyc;
        push_one(c + 1, 8'd5, 24'h0A0B0C);
        push_frame(c + 2, 24'h00FF00, -1);
        bus.host_valid = 1'b1;
        bus.host_led   = 8'd5;
        bus.host_rgb   = 24'h0A0B0C;
        do_cfg(2'd1, 24'h00FF00);
        bus.host_valid = 1'b0;
        run_until(c + 11);
        drained("cfg_host_drained");

        // Reset while index 4 is on the bus.
        c = cyc;
        for (int i = 0; i < 5; i++) push_one(c + 1 + i, 8'(i), 24'h000044);
        do_cfg(2'd1, 24'h000044);
        run_until(c + 5);
        reset    = 1'b1;
        last_led = 8'd0;
        last_rgb = 24'd0;
        tick();
        check("midrst_write", 32'(write), 32'd0);
        check("midrst_led", 32'(led_num), 32'd0);
        check("midrst_rgb", 32'(rgb_data), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        run_until(c + 60);
        drained("midrst_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
